// File: rtl/tour_pkg.sv
// tour_pkg: shared state type and command/response constants for tour_seq
package tour_pkg;
  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;
  localparam logic [3:0] OP_MOVE = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;
  localparam logic [3:0] OP_ABORT = 4'h0;
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;
endpackage

// File: rtl/tour_seq_if.sv
// tour_seq_if: tour memory, UART command and cmd_proc signals around tour_seq
// master: the sequencer (drives mv_indx, cmd, cmd_rdy, clr_cmd_rdy_UART, resp, tour_err)
// slave: its environment (drives start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp)
interface tour_seq_if;
  logic start_tour;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic [15:0] cmd_UART;
  logic cmd_rdy_UART;
  logic clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic send_resp;
  logic [7:0] resp;
  logic tour_err;
  modport master(
    input start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_err
  );
  modport slave(
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_err
  );
endinterface

// File: rtl/tour_seq_move_decode.sv
// move_decode: one-hot knight move to vertical and horizontal cmd_proc commands
// move_i: one-hot move; vert_cmd_o/horz_cmd_o: command pair; illegal_o: move not one-hot
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o,
  output logic        illegal_o
);
  logic north, east, v2, h2;
  always_comb begin
    north = |{move_i[7], move_i[2:0]};
    east = |{move_i[7:5], move_i[0]};
    v2 = |{move_i[5:4], move_i[1:0]};
    h2 = |{move_i[7:6], move_i[3:2]};
    vert_cmd_o = {OP_MOVE, north ? HDG_N : HDG_S, v2 ? 4'd2 : 4'd1};
    horz_cmd_o = {OP_FANFARE, east ? HDG_E : HDG_W, h2 ? 4'd2 : 4'd1};
    illegal_o = (move_i == 8'h00) || ((move_i & (move_i - 8'd1)) != 8'h00);
  end
endmodule

// File: rtl/tour_seq.sv
// tour_seq: expands a solved knight tour into cmd_proc commands, UART passthrough when idle
// clk, rst_n (async, active low); bus: tour_seq_if.master
// NUM_MOVES: moves in a tour; TOUR_ABORT_EN: UART opcode 0 aborts the tour at the next response
module tour_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input logic clk,
  input logic rst_n,
  tour_seq_if.master bus
);
  localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);
  state_t state_q;
  logic [4:0] mv_indx_q;
  logic tour_err_q, settle_q, abort_q;
  logic [15:0] vert_cmd, horz_cmd;
  logic illegal, last, in_wait, abort_seen, abort_now;
  move_decode u_dec (
    .move_i(bus.move),
    .vert_cmd_o(vert_cmd),
    .horz_cmd_o(horz_cmd),
    .illegal_o(illegal)
  );
  always_comb begin
    last = mv_indx_q == LAST;
    in_wait = state_q == WAIT_V || state_q == WAIT_H;
`ifdef TOUR_ABORT_EN
    abort_seen = state_q != IDLE && bus.cmd_rdy_UART && bus.cmd_UART[15:12] == OP_ABORT;
`else
    abort_seen = 1'b0;
`endif
    abort_now = abort_q | abort_seen;
    bus.cmd = state_q == IDLE ? bus.cmd_UART
            : (state_q == VERT || state_q == WAIT_V) ? vert_cmd : horz_cmd;
    // settle_q covers the tour memory read latency after mv_indx changes
    bus.cmd_rdy = state_q == IDLE ? bus.cmd_rdy_UART
                : state_q == HORZ || (state_q == VERT && !settle_q && !illegal);
    bus.clr_cmd_rdy_UART = state_q == IDLE ? bus.clr_cmd_rdy : abort_seen;
    bus.resp = (state_q == IDLE || (state_q == WAIT_H && last) || (in_wait && abort_now))
             ? RESP_ACK : RESP_POS;
    bus.mv_indx = mv_indx_q;
    bus.tour_err = tour_err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mv_indx_q <= '0;
      tour_err_q <= 1'b0;
      settle_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      tour_err_q <= 1'b0;
      settle_q <= 1'b0;
      abort_q <= abort_now && state_q != IDLE;
      case (state_q)
        IDLE: if (bus.start_tour) begin
          state_q <= VERT;
          mv_indx_q <= '0;
          settle_q <= 1'b1;
        end
        VERT: if (!settle_q) begin
          if (illegal) begin
            state_q <= IDLE;
            tour_err_q <= 1'b1;
            abort_q <= 1'b0;
          end else if (bus.clr_cmd_rdy) state_q <= WAIT_V;
        end
        WAIT_V: if (bus.send_resp) begin
          state_q <= abort_now ? IDLE : HORZ;
          abort_q <= 1'b0;
        end
        HORZ: if (bus.clr_cmd_rdy) state_q <= WAIT_H;
        WAIT_H: if (bus.send_resp) begin
          abort_q <= 1'b0;
          if (last || abort_now) state_q <= IDLE;
          else begin
            state_q <= VERT;
            mv_indx_q <= mv_indx_q + 5'd1;
            settle_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tour_seq.sv
// tb_tour_seq: randomized self-checking bench for tour_seq against a move-table model
module tb_tour_seq;
  localparam int NUM = 24;
`ifdef TOUR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [32];
  int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  tour_seq_if bus();
  tour_seq #(.NUM_MOVES(NUM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.move <= mem[bus.mv_indx];
  function automatic int bitpos(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction
  function automatic logic [15:0] exp_vert(input logic [7:0] m);
    int dy = DY[bitpos(m)];
    logic [3:0] n = 4'(dy < 0 ? -dy : dy);
    return {4'h4, dy > 0 ? 8'h00 : 8'h7F, n};
  endfunction
  function automatic logic [15:0] exp_horz(input logic [7:0] m);
    int dx = DX[bitpos(m)];
    logic [3:0] n = 4'(dx < 0 ? -dx : dx);
    return {4'h5, dx > 0 ? 8'hBF : 8'h3F, n};
  endfunction
  task automatic fill_random;
    for (int i = 0; i < 32; i++) mem[i] = 8'h01 << $urandom_range(7, 0);
  endtask
  task automatic start;
    @(negedge clk);
    bus.start_tour = 1'b1;
    @(negedge clk);
    bus.start_tour = 1'b0;
  endtask
  task automatic do_cmd(input logic [15:0] e, input logic [7:0] r, input bit inj, input string nm);
    int n = 0;
    while (bus.cmd_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy: cmd_rdy=%b after %0d cycles, required 1", nm, bus.cmd_rdy, n);
      return;
    end
    repeat ($urandom_range(2, 0)) begin
      checks++;
      if (bus.cmd !== e) begin errors++; $display("FAIL %s_hold: cmd=%h required %h", nm, bus.cmd, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.cmd !== e) begin errors++; $display("FAIL %s_cmd: cmd=%h required %h", nm, bus.cmd, e); end
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp = 1'($urandom_range(1, 0));
    #1;
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL %s_clr_uart: clr_cmd_rdy_UART=%b required 0", nm, bus.clr_cmd_rdy_UART); end
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL %s_wait: cmd_rdy=%b required 0", nm, bus.cmd_rdy); end
    if (inj) begin
      bus.cmd_UART = 16'h0000;
      bus.cmd_rdy_UART = 1'b1;
      #1;
      checks++;
      if (bus.clr_cmd_rdy_UART !== ABORT) begin errors++; $display("FAIL %s_abort_clr: clr_cmd_rdy_UART=%b required %b", nm, bus.clr_cmd_rdy_UART, ABORT); end
      @(negedge clk);
      bus.cmd_UART = 16'h2000;
    end
    repeat ($urandom_range(2, 0)) @(negedge clk);
    bus.send_resp = 1'b1;
    checks++;
    if (bus.resp !== r) begin errors++; $display("FAIL %s_resp: resp=%h required %h", nm, bus.resp, r); end
    @(negedge clk);
    bus.send_resp = 1'b0;
  endtask
  task automatic tour_steps(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      do_cmd(exp_vert(mem[i]), 8'h5A, 1'b0, "vert");
      checks++;
      if (bus.mv_indx !== 5'(i)) begin errors++; $display("FAIL mv_indx: mv_indx=%0d required %0d", bus.mv_indx, i); end
      do_cmd(exp_horz(mem[i]), i == NUM - 1 ? 8'hA5 : 8'h5A, 1'b0, "horz");
    end
  endtask
  task automatic check_idle(input string nm, input logic [4:0] idx);
    logic [15:0] u = 16'($urandom);
    bus.cmd_UART = u;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.cmd !== u || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL %s_pass: cmd=%h rdy=%b required %h 1", nm, bus.cmd, bus.cmd_rdy, u); end
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL %s_clr: clr_cmd_rdy_UART=%b required 1", nm, bus.clr_cmd_rdy_UART); end
    checks++;
    if (bus.resp !== 8'hA5) begin errors++; $display("FAIL %s_resp: resp=%h required a5", nm, bus.resp); end
    checks++;
    if (bus.mv_indx !== idx) begin errors++; $display("FAIL %s_idx: mv_indx=%0d required %0d", nm, bus.mv_indx, idx); end
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_UART = 16'h2000;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'h2000;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.cmd !== 16'h2000 || bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_pass: cmd=%h rdy=%b required 2000 1", bus.cmd, bus.cmd_rdy); end
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL reset_clr: clr_cmd_rdy_UART=%b required 1", bus.clr_cmd_rdy_UART); end
    checks++;
    if (bus.resp !== 8'hA5 || bus.mv_indx !== 5'd0 || bus.tour_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: resp=%h mv_indx=%0d tour_err=%b required a5 0 0", bus.resp, bus.mv_indx, bus.tour_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL reset_clr_low: clr_cmd_rdy_UART=%b required 0", bus.clr_cmd_rdy_UART); end
  endtask
  task automatic test_directed_tour;
    logic [7:0] mv [5] = '{8'h01, 8'h08, 8'h10, 8'h40, 8'h80};
    logic [15:0] ev [5] = '{16'h4002, 16'h47F1, 16'h47F2, 16'h47F1, 16'h4001};
    logic [15:0] eh [5] = '{16'h5BF1, 16'h53F2, 16'h53F1, 16'h5BF2, 16'h5BF2};
    fill_random();
    for (int i = 0; i < 5; i++) mem[i] = mv[i];
    start();
    for (int i = 0; i < 5; i++) begin
      do_cmd(ev[i], 8'h5A, 1'b0, "dir_vert");
      do_cmd(eh[i], 8'h5A, 1'b0, "dir_horz");
      checks++;
      if (bus.mv_indx !== 5'(i + 1)) begin errors++; $display("FAIL dir_idx: mv_indx=%0d required %0d", bus.mv_indx, i + 1); end
    end
    tour_steps(5, NUM - 1);
    check_idle("dir_end", 5'(NUM - 1));
  endtask
  task automatic test_random_tour;
    fill_random();
    start();
    tour_steps(0, 2);
    bus.start_tour = 1'b1;
    @(negedge clk);
    bus.start_tour = 1'b0;
    tour_steps(3, NUM - 1);
    check_idle("rnd_end", 5'(NUM - 1));
  endtask
  task automatic test_illegal;
    for (int k = 0; k < 3; k++) begin
      int idx = k == 0 ? 5 : $urandom_range(NUM - 2, 1);
      logic [7:0] bad = k == 0 ? 8'h03 : k == 1 ? 8'h00 : 8'h81 | (8'h01 << $urandom_range(6, 1));
      int errs = 0, rdys = 0;
      fill_random();
      mem[idx] = bad;
      bus.cmd_rdy_UART = 1'b0;
      start();
      tour_steps(0, idx - 1);
      repeat (6) begin
        @(negedge clk);
        if (bus.tour_err === 1'b1) errs++;
        if (bus.cmd_rdy !== 1'b0) rdys++;
      end
      checks++;
      if (errs != 1) begin errors++; $display("FAIL illegal_err: tour_err pulses=%0d required 1 (move %h)", errs, bad); end
      checks++;
      if (rdys != 0) begin errors++; $display("FAIL illegal_rdy: cmd_rdy cycles=%0d required 0", rdys); end
      check_idle("illegal_idle", 5'(idx));
    end
  endtask
  task automatic test_uart_abort;
    fill_random();
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'h2000;
    start();
    tour_steps(0, 0);
`ifdef TOUR_ABORT_EN
    do_cmd(exp_vert(mem[1]), 8'hA5, 1'b1, "abort_vert");
    check_idle("abort_idle", 5'd1);
`else
    do_cmd(exp_vert(mem[1]), 8'h5A, 1'b1, "noabort_vert");
    do_cmd(exp_horz(mem[1]), 8'h5A, 1'b0, "noabort_horz");
    tour_steps(2, NUM - 1);
    check_idle("noabort_end", 5'(NUM - 1));
`endif
  endtask
  task automatic test_reset_mid;
    fill_random();
    start();
    tour_steps(0, 2);
    repeat (2) @(negedge clk);
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'h2000;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.cmd !== 16'h2000 || bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: mv_indx=%0d cmd=%h rdy=%b required 0 2000 1", bus.mv_indx, bus.cmd, bus.cmd_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("mid_idle", 5'd0);
    start();
    tour_steps(0, NUM - 1);
    check_idle("mid_end", 5'(NUM - 1));
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    bus.start_tour = 1'b0;
    bus.cmd_UART = 16'h2000;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    test_reset();
    test_directed_tour();
    test_random_tour();
    test_illegal();
    test_uart_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tour_seq.md
# tour_seq

Tour command sequencer between the tour solver's move memory, the UART command path and `cmd_proc`. When a tour is started it walks the solved move list and expands each knight move into two `cmd_proc` commands: a vertical move, then a horizontal move with fanfare. It is the only source of `cmd`/`cmd_rdy` seen by `cmd_proc`, and it selects the response byte returned over UART.

## Interface
- `NUM_MOVES`, default 24: number of knight moves in a full 5x5 tour.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous reset, active low.
- `start_tour  in  1`: one-cycle pulse from the tour solver when the move list is valid.
- `move  in  8`: one-hot move read from tour memory at `mv_indx`.
- `mv_indx  out  5`: index of the move currently being executed.
- `cmd_UART  in  16`: command from the UART wrapper.
- `cmd_rdy_UART  in  1`: UART command valid.
- `clr_cmd_rdy_UART  out  1`: clears UART `cmd_rdy`.
- `cmd  out  16`: command to `cmd_proc`.
- `cmd_rdy  out  1`: command valid to `cmd_proc`.
- `clr_cmd_rdy  in  1`: `cmd_proc` has consumed `cmd`.
- `send_resp  in  1`: `cmd_proc` has finished the current command.
- `resp  out  8`: response byte sent to UART on `send_resp`.
- `tour_err  out  1`: one-cycle pulse when an illegal move is read.

## Operation
- States:
  - IDLE: UART passthrough. `cmd=cmd_UART`, `cmd_rdy=cmd_rdy_UART`, `clr_cmd_rdy_UART=clr_cmd_rdy`.
  - VERT, WAIT_V, HORZ, WAIT_H: tour mode. `cmd_rdy_UART` is ignored, `clr_cmd_rdy_UART=0`.
- Transitions:
  - IDLE -> VERT on `start_tour`; `mv_indx` is cleared to 0.
  - VERT holds `cmd_rdy=1` until `clr_cmd_rdy`, then goes to WAIT_V.
  - WAIT_V -> HORZ on `send_resp`.
  - HORZ holds `cmd_rdy=1` until `clr_cmd_rdy`, then goes to WAIT_H.
  - WAIT_H on `send_resp`:
    - if `mv_indx==NUM_MOVES-1` -> IDLE;
    - otherwise `mv_indx++` and -> VERT.
- Command encoding:
  - Vertical: opcode 4. Heading 8'h00 for north, 8'h7F for south. Squares in [3:0].
  - Horizontal: opcode 5 (fanfare). Heading 8'hBF for east, 8'h3F for west.
- Move decode, bit -> (dx,dy):
  - 0: (+1,+2); 1: (-1,+2); 2: (-2,+1); 3: (-2,-1)
  - 4: (-1,-2); 5: (+1,-2); 6: (+2,-1); 7: (+2,+1)
  - Example: move 0 gives 16'h4002 then 16'h5BF1. Move 3 gives 16'h47F1 then 16'h53F2.
- Illegal move: `move` not one-hot while in VERT. The block issues no command, pulses `tour_err`, and returns to IDLE.
- Response:
  - `resp=8'hA5` in IDLE, and in WAIT_H when `mv_indx==NUM_MOVES-1`.
  - `resp=8'h5A` in all other tour states.
- `start_tour` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, `mv_indx=0`, `tour_err=0`.
  - `cmd_rdy` and `cmd` follow the IDLE passthrough of `cmd_rdy_UART`/`cmd_UART`.
  - `resp=8'hA5`.
- `cmd`, `cmd_rdy` and `resp` are combinational from registered state, `mv_indx` and `move`.
- `move` must be valid one cycle after `mv_indx` changes (synchronous tour memory). VERT waits one cycle after entry before asserting `cmd_rdy`.
- `cmd` stays stable while `cmd_rdy=1`.
- If `clr_cmd_rdy` and `send_resp` arrive in the same cycle in VERT/HORZ, `clr_cmd_rdy` wins; `send_resp` is only honoured in WAIT states.
- Reset mid-tour returns to IDLE immediately; the tour is lost.

## Configuration
- `TOUR_ABORT_EN` defined:
  - A `cmd_rdy_UART` with opcode 4'h0 (abort) seen in any tour state pulses `clr_cmd_rdy_UART` and forces IDLE at the next WAIT state's `send_resp`. The command in flight completes.
  - `resp=8'hA5` on that `send_resp`.
- `TOUR_ABORT_EN` undefined: UART input is fully ignored during a tour; `cmd_rdy_UART` stays pending until IDLE.

## Structure
- Shared package `tour_pkg` holds:
  - state enum;
  - opcode constants (`OP_MOVE=4'h4`, `OP_FANFARE=4'h5`, `OP_ABORT=4'h0`);
  - heading constants (`HDG_N`, `HDG_S`, `HDG_E`, `HDG_W`);
  - response bytes (`RESP_ACK=8'hA5`, `RESP_POS=8'h5A`).
- One combinational sub-module `move_decode`: one-hot move -> `{vert_cmd, horz_cmd, illegal}`.

## Test plan
- Reset, `cmd_rdy_UART=1`, `cmd_UART=16'h2000` -> `cmd=16'h2000`, `cmd_rdy=1`; `clr_cmd_rdy` is mirrored on `clr_cmd_rdy_UART`; `resp=8'hA5`.
- `start_tour`, `move=8'h01` -> `cmd=16'h4002` with `resp=8'h5A` on `send_resp`; then `cmd=16'h5BF1`, and `mv_indx` goes 0->1 after `send_resp`.
- Moves 8'h08, 8'h10, 8'h40, 8'h80 -> command pairs 47F1/53F2, 47F2/53F1, 47F1/5BF2, 4001/5BF2.
- 24 moves completed -> `resp=8'hA5` on the final `send_resp`, state IDLE, `cmd_rdy` follows UART.
- `move=8'h03` at index 5 -> `tour_err` pulses, no `cmd_rdy`, state IDLE.
- With `TOUR_ABORT_EN`, UART 16'h0000 during WAIT_V -> IDLE after that `send_resp`, `resp=8'hA5`, `mv_indx` unchanged.
